// File: rtl/game_flow_ctrl.sv
// Game sequencer for the player/ball datapath: title, play, dying, victory and game-over phases.
// Owns game_time, score and lives; every output is registered, so a state change shows one cycle after its cause.
module game_flow_ctrl #(
    parameter int TIME_START     = 600,
    parameter int FRAMES_PER_SEC = 64,
    parameter int LIVES_START    = 3,
    parameter int FALL_Y         = 460,
    parameter int GOAL_X         = 620,
    parameter int COIN_POINTS    = 10,
    parameter int DEATH_HOLD     = 120
) (
    input  logic       clk_50,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic       coin_hit,
    output logic [2:0] game_state,
    output logic       respawn,
    output logic       freeze,
    output logic [9:0] game_time,
    output logic [15:0] score,
    output logic [2:0] lives,
    output logic       end_flag
);

    localparam logic [2:0] TITLE     = 3'd0;
    localparam logic [2:0] PLAY      = 3'd1;
    localparam logic [2:0] DYING     = 3'd2;
    localparam logic [2:0] VICTORY   = 3'd3;
    localparam logic [2:0] GAME_OVER = 3'd4;

    localparam logic [9:0]  TIME_LOAD  = 10'(TIME_START);
    localparam logic [5:0]  FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
    localparam logic [2:0]  LIVES_LOAD = 3'(LIVES_START);
    localparam logic [9:0]  FALL_LIM   = 10'(FALL_Y);
    localparam logic [9:0]  GOAL_LIM   = 10'(GOAL_X);
    localparam logic [16:0] COIN_ADD   = 17'(COIN_POINTS);
    localparam logic [6:0]  HOLD_LAST  = 7'(DEATH_HOLD - 1);
    localparam logic [7:0]  KEY_ENTER  = 8'h28;

    logic [2:0]  frameSync;
    logic        frameTick;
    logic        prevEnter;
    logic [5:0]  frameCnt;
    logic [6:0]  holdCnt;

    logic        enterEvt;
    logic [16:0] scorePlusCoin;
    logic [15:0] scoreCoinSat;
    logic [15:0] scoreBonusSat;
    logic [2:0]  stateNxt;
    logic        respawnNxt;
    logic [9:0]  timeNxt;
    logic [15:0] scoreNxt;
    logic [2:0]  livesNxt;
    logic [5:0]  frameNxt;
    logic [6:0]  holdNxt;

    assign enterEvt      = (keycode == KEY_ENTER) && !prevEnter;
    assign scorePlusCoin = {1'b0, score} + COIN_ADD;
    assign scoreCoinSat  = scorePlusCoin[16] ? 16'hFFFF : scorePlusCoin[15:0];
    assign scoreBonusSat = (score == 16'hFFFF) ? score : score + 16'd1;

    always_comb begin
        stateNxt   = game_state;
        respawnNxt = 1'b0;
        timeNxt    = game_time;
        scoreNxt   = score;
        livesNxt   = lives;
        frameNxt   = frameCnt;
        holdNxt    = holdCnt;
        case (game_state)
            TITLE: begin
                if (enterEvt) begin
                    stateNxt   = PLAY;
                    respawnNxt = 1'b1;
                    scoreNxt   = 16'd0;
                    livesNxt   = LIVES_LOAD;
                    timeNxt    = TIME_LOAD;
                    frameNxt   = 6'd0;
                end
            end
            PLAY: begin
                if (coin_hit)
                    scoreNxt = scoreCoinSat;
                // Leaving PLAY swallows a coincident tick so game_time freezes at the cause value.
                if (player_y >= FALL_LIM || game_time == 10'd0) begin
                    stateNxt = DYING;
                    livesNxt = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                    holdNxt  = 7'd0;
                end else if (player_x >= GOAL_LIM) begin
                    stateNxt = VICTORY;
                end else if (frameTick) begin
                    if (frameCnt == FRAME_LAST) begin
                        frameNxt = 6'd0;
                        timeNxt  = game_time - 10'd1;
                    end else begin
                        frameNxt = frameCnt + 6'd1;
                    end
                end
            end
            DYING: begin
                if (frameTick) begin
                    if (holdCnt == HOLD_LAST) begin
                        if (lives == 3'd0) begin
                            stateNxt = GAME_OVER;
                        end else begin
                            stateNxt   = PLAY;
                            respawnNxt = 1'b1;
                            timeNxt    = TIME_LOAD;
                            frameNxt   = 6'd0;
                        end
                    end else begin
                        holdNxt = holdCnt + 7'd1;
                    end
                end
            end
            VICTORY: begin
                // Time bonus drains one second per frame; Enter only counts once it is spent.
                if (frameTick && game_time != 10'd0) begin
                    timeNxt  = game_time - 10'd1;
                    scoreNxt = scoreBonusSat;
                end
                if (enterEvt && game_time == 10'd0)
                    stateNxt = TITLE;
            end
            GAME_OVER: begin
                if (enterEvt)
                    stateNxt = TITLE;
            end
            default: stateNxt = TITLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge Reset) begin
        if (!Reset) begin
            frameSync  <= 3'b000;
            frameTick  <= 1'b0;
            prevEnter  <= 1'b0;
            frameCnt   <= 6'd0;
            holdCnt    <= 7'd0;
            game_state <= TITLE;
            respawn    <= 1'b0;
            freeze     <= 1'b1;
            game_time  <= TIME_LOAD;
            score      <= 16'd0;
            lives      <= LIVES_LOAD;
            end_flag   <= 1'b0;
        end else begin
            frameSync  <= {frameSync[1:0], frame_clk};
            frameTick  <= frameSync[1] & ~frameSync[2];
            prevEnter  <= (keycode == KEY_ENTER);
            frameCnt   <= frameNxt;
            holdCnt    <= holdNxt;
            game_state <= stateNxt;
            respawn    <= respawnNxt;
            freeze     <= (stateNxt != PLAY);
            game_time  <= timeNxt;
            score      <= scoreNxt;
            lives      <= livesNxt;
            end_flag   <= (stateNxt == VICTORY);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a full-size instance plus a short-timer instance for the timeout and victory paths.
module tb_game_flow_ctrl;

    logic        clk_50 = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [7:0]  keyM = 8'h00, keyF = 8'h00;
    logic [9:0]  xM = 10'd100, yM = 10'd100, xF = 10'd100, yF = 10'd100;
    logic        coinM = 1'b0, coinF = 1'b0;

    logic [2:0]  stateM, stateF, livesM, livesF;
    logic        respawnM, respawnF, freezeM, freezeF, endM, endF;
    logic [9:0]  timeM, timeF;
    logic [15:0] scoreM, scoreF;

    int checks = 0;
    int failures = 0;
    int respawnCntM = 0;
    int respawnCntF = 0;
    int baseCnt;

    always #10 clk_50 = ~clk_50;

    game_flow_ctrl dutMain (
        .clk_50(clk_50), .Reset(Reset), .frame_clk(frame_clk), .keycode(keyM),
        .player_x(xM), .player_y(yM), .coin_hit(coinM),
        .game_state(stateM), .respawn(respawnM), .freeze(freezeM), .game_time(timeM),
        .score(scoreM), .lives(livesM), .end_flag(endM)
    );

    game_flow_ctrl #(.TIME_START(8), .FRAMES_PER_SEC(4)) dutFast (
        .clk_50(clk_50), .Reset(Reset), .frame_clk(frame_clk), .keycode(keyF),
        .player_x(xF), .player_y(yF), .coin_hit(coinF),
        .game_state(stateF), .respawn(respawnF), .freeze(freezeF), .game_time(timeF),
        .score(scoreF), .lives(livesF), .end_flag(endF)
    );

    always @(negedge clk_50) begin
        if (respawnM === 1'b1) respawnCntM <= respawnCntM + 1;
        if (respawnF === 1'b1) respawnCntF <= respawnCntF + 1;
    end

    task automatic expectEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            waitCycles(4);
            frame_clk = 1'b0;
            waitCycles(4);
        end
    endtask

    task automatic enterM();
        keyM = 8'h28; waitCycles(1); keyM = 8'h00; waitCycles(2);
    endtask

    task automatic enterF();
        keyF = 8'h28; waitCycles(1); keyF = 8'h00; waitCycles(2);
    endtask

    task automatic fallM();
        yM = 10'd460; waitCycles(1); yM = 10'd100; waitCycles(2);
    endtask

    task automatic doReset();
        Reset = 1'b0; waitCycles(2); Reset = 1'b1; waitCycles(2);
    endtask

    initial begin
        doReset();
        expectEq("rst_state", stateM, 0);
        expectEq("rst_score", scoreM, 0);
        expectEq("rst_lives", livesM, 3);
        expectEq("rst_time", timeM, 600);
        expectEq("rst_freeze", freezeM, 1);
        expectEq("rst_end", endM, 0);

        // Held Enter produces exactly one start event
        baseCnt = respawnCntM;
        keyM = 8'h28; waitCycles(10); keyM = 8'h00; waitCycles(2);
        expectEq("start_respawns", respawnCntM - baseCnt, 1);
        expectEq("start_state", stateM, 1);
        expectEq("start_freeze", freezeM, 0);
        baseCnt = respawnCntM;
        keyM = 8'h28; waitCycles(3); keyM = 8'h00; waitCycles(2);
        expectEq("repress_state", stateM, 1);
        expectEq("repress_respawns", respawnCntM - baseCnt, 0);

        frameTicks(128);
        expectEq("time_after_128", timeM, 598);
        for (int i = 0; i < 3; i++) begin
            coinM = 1'b1; waitCycles(1); coinM = 1'b0; waitCycles(1);
        end
        expectEq("coins_score", scoreM, 30);

        // Fall with a coincident coin
        yM = 10'd460; coinM = 1'b1; waitCycles(1);
        yM = 10'd100; coinM = 1'b0; waitCycles(1);
        expectEq("fall_state", stateM, 2);
        expectEq("fall_score", scoreM, 40);
        expectEq("fall_lives", livesM, 2);
        expectEq("fall_freeze", freezeM, 1);
        coinM = 1'b1; waitCycles(1); coinM = 1'b0; waitCycles(1);
        expectEq("dying_coin_ignored", scoreM, 40);
        baseCnt = respawnCntM;
        frameTicks(119);
        expectEq("hold_119_state", stateM, 2);
        frameTicks(1);
        expectEq("respawn_state", stateM, 1);
        expectEq("respawn_pulse", respawnCntM - baseCnt, 1);
        expectEq("respawn_time", timeM, 600);
        expectEq("respawn_score", scoreM, 40);

        // Asynchronous reset mid-PLAY
        Reset = 1'b0; #1;
        expectEq("midrst_state", stateM, 0);
        expectEq("midrst_score", scoreM, 0);
        expectEq("midrst_lives", livesM, 3);
        expectEq("midrst_time", timeM, 600);
        expectEq("midrst_freeze", freezeM, 1);
        expectEq("midrst_respawn", respawnM, 0);
        waitCycles(2); Reset = 1'b1; waitCycles(2);

        // Lose all lives
        enterM();
        fallM(); expectEq("go_lives2", livesM, 2);
        frameTicks(120);
        fallM(); expectEq("go_lives1", livesM, 1);
        frameTicks(120);
        fallM();
        expectEq("go_lives0", livesM, 0);
        expectEq("go_dying", stateM, 2);
        baseCnt = respawnCntM;
        frameTicks(120);
        expectEq("go_state", stateM, 4);
        expectEq("go_no_respawn", respawnCntM - baseCnt, 0);
        expectEq("go_freeze", freezeM, 1);
        enterM();
        expectEq("go_to_title", stateM, 0);

        // Short-timer instance: timeout path
        doReset();
        enterF();
        frameTicks(28);
        expectEq("fast_time1", timeF, 1);
        expectEq("fast_play", stateF, 1);
        frameTicks(4);
        expectEq("timeout_state", stateF, 2);
        expectEq("timeout_time", timeF, 0);
        expectEq("timeout_lives", livesF, 2);

        // Short-timer instance: victory and time bonus
        doReset();
        enterF();
        frameTicks(12);
        expectEq("vic_pre_time", timeF, 5);
        for (int i = 0; i < 2; i++) begin
            coinF = 1'b1; waitCycles(1); coinF = 1'b0; waitCycles(1);
        end
        xF = 10'd620; waitCycles(1); xF = 10'd100; waitCycles(1);
        expectEq("vic_state", stateF, 3);
        expectEq("vic_end", endF, 1);
        expectEq("vic_freeze", freezeF, 1);
        expectEq("vic_score", scoreF, 20);
        enterF();
        expectEq("vic_early_enter", stateF, 3);
        frameTicks(5);
        expectEq("bonus_time", timeF, 0);
        expectEq("bonus_score", scoreF, 25);
        frameTicks(1);
        expectEq("bonus_sat_time", timeF, 0);
        expectEq("bonus_sat_score", scoreF, 25);
        enterF();
        expectEq("vic_to_title", stateF, 0);
        expectEq("vic_end_clear", endF, 0);
        expectEq("vic_score_held", scoreF, 25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the player/ball datapath. Runs title, play, death/respawn, victory and game-over phases. Owns the game timer, score and lives, and drives respawn/freeze controls into the player movement block. Runs in the clk_50 domain; frame_clk is synchronized and used only as a frame tick.

Parameters:
TIME_START, 600, game_time load value on new game or respawn
FRAMES_PER_SEC, 64, frame ticks per game_time decrement
LIVES_START, 3, lives loaded on new game
FALL_Y, 460, player_y at or above this is a death by falling
GOAL_X, 620, player_x at or above this is a level clear
COIN_POINTS, 10, score added per coin_hit pulse
DEATH_HOLD, 120, frame ticks spent in DYING before respawn or game over

Ports:
clk_50  in  1  system clock
Reset  in  1  asynchronous, active-low reset (0 = reset)
frame_clk  in  1  vertical-sync-rate clock, asynchronous to clk_50
keycode  in  8  current USB keycode; 0x28 = Enter
player_x  in  10  player screen X from the movement block
player_y  in  10  player screen Y from the movement block
coin_hit  in  1  single clk_50-cycle pulse per coin/question-block collection
game_state  out  3  0 TITLE, 1 PLAY, 2 DYING, 3 VICTORY, 4 GAME_OVER
respawn  out  1  one-cycle pulse; movement block reloads its start position
freeze  out  1  1 = movement block ignores keys and holds position
game_time  out  10  seconds remaining
score  out  16  accumulated score
lives  out  3  lives remaining
end_flag  out  1  1 while in VICTORY

Behaviour:
- Reset (async, Reset=0): game_state=TITLE, respawn=0, freeze=1, game_time=TIME_START, score=0, lives=LIVES_START, end_flag=0. Frame counter, hold counter and synchronizers clear. Reset mid-operation aborts any state immediately.
- frame tick: frame_clk passes a 2-FF synchronizer, then a rising-edge detect. The tick is a 1-cycle pulse 3 clk_50 cycles after the frame_clk rise.
- enter event: keycode==0x28 this cycle and !=0x28 in the previous cycle. A held key produces exactly one event.
- All outputs are registered. A state change is visible the cycle after its condition is sampled.
- TITLE: freeze=1. On enter event -> PLAY, with respawn=1 for that one cycle. Load score=0, lives=LIVES_START, game_time=TIME_START, frame counter=0.
- PLAY: freeze=0.
  - Each tick increments the 6-bit frame counter. A tick with counter==FRAMES_PER_SEC-1 wraps it to 0 and decrements game_time, saturating at 0.
  - coin_hit adds COIN_POINTS to score, saturating at 0xFFFF.
  - Priority each cycle: (1) player_y>=FALL_Y or game_time==0 -> DYING, lives-=1 (saturate 0), hold counter=0. (2) Else player_x>=GOAL_X -> VICTORY.
  - In the transition cycle, a coincident coin_hit is still scored; a coincident tick does not change game_time.
- DYING: freeze=1. Ticks increment the hold counter. When a tick finds hold==DEATH_HOLD-1:
  - lives==0 -> GAME_OVER.
  - otherwise -> PLAY with a respawn pulse, game_time=TIME_START, frame counter=0.
  - Score is preserved in both cases. coin_hit is ignored.
- VICTORY: freeze=1, end_flag=1. Each tick with game_time!=0: game_time-=1 and score+=1 (saturating); this is the time bonus at one second per frame. Enter events are ignored until game_time==0; after that, enter -> TITLE (score held for display until the next game start).
- GAME_OVER: freeze=1. Enter event -> TITLE.
- respawn is never asserted outside the PLAY-entry cycles. end_flag=0 in every state except VICTORY.
- Undefined game_state encodings 5-7 -> TITLE on the next cycle.

Test Plan:
- Reset low mid-PLAY (score=40, lives=2) -> next observation: state 0, score 0, lives 3, game_time 600, freeze 1, respawn 0.
- TITLE, keycode held at 0x28 for 10 cycles -> exactly one respawn pulse, state 1; release and re-press in PLAY -> no effect.
- PLAY, 128 frame_clk rises -> game_time 598; three coin_hit pulses -> score 30; 700 s worth of ticks -> game_time saturates at 0 and state goes to DYING with lives 2.
- PLAY, player_y=460 with coin_hit in the same cycle -> DYING, score +10, lives 3->2; after 120 ticks -> PLAY, respawn pulse, game_time 600, score kept.
- lives=1 death -> DYING -> after 120 ticks GAME_OVER (state 4); enter -> TITLE.
- PLAY, player_x=620 with game_time=5, score=20 -> VICTORY, end_flag 1; 5 ticks -> game_time 0, score 25; a 6th tick changes nothing; enter -> TITLE, end_flag 0.
